// File: rtl/alu_pkg.sv
// Shared definitions for the chunked ALU sequencer: opsel codes, op-class
// decode and FSM state encoding.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_ADC = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SBC = 3'b110,
        OP_ILL = 3'b111
    } opsel_e;

    typedef enum logic [1:0] {
        CLS_CHAINED = 2'd0,
        CLS_FIXED   = 2'd1,
        CLS_ILLEGAL = 2'd2
    } op_class_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Chained ops propagate carry between chunks; fixed ops force carry-in to 0.
    function automatic op_class_e op_class(input logic [2:0] op);
        op_class_e cls;
        case (opsel_e'(op))
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: cls = CLS_CHAINED;
            OP_AND, OP_OR, OP_XOR:          cls = CLS_FIXED;
            default:                        cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_chunk_seq.sv
// Sequences one request into NUM_CHUNKS ALU chunk operations, chaining the
// carry between chunks for arithmetic ops and reporting the final carry.
module alu_chunk_seq
    import alu_pkg::*;
#(
    parameter int NUM_CHUNKS = 4,
    parameter int IDX_W      = $clog2(NUM_CHUNKS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_opsel,
    input  logic             req_cin,
    input  logic             flush,
    output logic             alu_en,
    output logic [2:0]       alu_opsel,
    output logic             alu_c_in,
    output logic [IDX_W-1:0] chunk_idx,
    input  logic             alu_c_out,
    output logic             done_valid,
    output logic             done_cout,
    output logic             done_err,
    output logic             flag_c
);

    state_e           state_q;
    state_e           state_d;
    logic [2:0]       opsel_q;
    logic             carry_q;
    logic             err_q;
    logic [IDX_W-1:0] idx_q;
    logic             accept;
    logic             last_chunk;
    logic             chained;

    assign req_ready  = (state_q == ST_IDLE) && !flush;
    assign accept     = req_valid && req_ready;
    assign last_chunk = (idx_q == IDX_W'(NUM_CHUNKS - 1));
    assign chained    = (op_class(opsel_q) == CLS_CHAINED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (op_class(req_opsel) == CLS_ILLEGAL) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (last_chunk) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // carry_q holds the latched cin before chunk 0, then each chunk's carry-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opsel_q <= 3'b000;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            flag_c  <= 1'b0;
        end else begin
            if (accept) begin
                opsel_q <= req_opsel;
                carry_q <= req_cin;
                err_q   <= (op_class(req_opsel) == CLS_ILLEGAL);
                idx_q   <= '0;
            end else if (state_q == ST_RUN) begin
                carry_q <= alu_c_out;
                idx_q   <= (flush || last_chunk) ? '0 : idx_q + 1'b1;
            end
            if (done_valid && !err_q) begin
                flag_c <= done_cout;
            end
        end
    end

    assign alu_en     = (state_q == ST_RUN);
    assign alu_opsel  = opsel_q;
    assign alu_c_in   = alu_en && chained && carry_q;
    assign chunk_idx  = alu_en ? idx_q : '0;
    // A flush landing in the DONE cycle suppresses the completion entirely.
    assign done_valid = (state_q == ST_DONE) && !flush;
    assign done_err   = done_valid && err_q;
    assign done_cout  = done_valid && !err_q && chained && carry_q;

endmodule
